// File: rtl/ip_spike_sequencer_pkg.sv
// ip_spike_sequencer_pkg: shared sizes, FSM encoding and step clamping for the spike sequencer.
package ip_spike_sequencer_pkg;
   localparam int WIDTH  = 256;
   localparam int IDX_W  = 8;
   localparam int ADDR_W = 16;
   localparam int DEPTH  = 1002;
   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_LOAD,
      S_SCAN,
      S_DONE
   } state_e;
   // The RAM only has DEPTH rows, so longer runs are cut at the last row.
   function automatic logic [ADDR_W-1:0] clamp_steps(input logic [ADDR_W-1:0] n);
      return (n > ADDR_W'(DEPTH)) ? ADDR_W'(DEPTH) : n;
   endfunction
endpackage

// File: rtl/ip_spike_sequencer_if.sv
// ip_spike_sequencer_if: run control, spike-RAM read port and spike stream of the sequencer.
interface ip_spike_sequencer_if;
   import ip_spike_sequencer_pkg::*;
   logic              start;
   logic [ADDR_W-1:0] num_steps;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [WIDTH-1:0]  ram_data;
   logic              spk_valid;
   logic              spk_ready;
   logic [IDX_W-1:0]  spk_idx;
   logic [ADDR_W-1:0] spk_step;
   logic              spk_last;
   logic              step_done;
   logic              busy;
   logic              done;
   modport master (
      input  start, num_steps, ram_data, spk_ready,
      output ram_addr, ram_we, spk_valid, spk_idx, spk_step, spk_last, step_done, busy, done
   );
   modport slave (
      output start, num_steps, ram_data, spk_ready,
      input  ram_addr, ram_we, spk_valid, spk_idx, spk_step, spk_last, step_done, busy, done
   );
endinterface

// File: rtl/ip_spike_sequencer_prio_enc.sv
// spike_prio_enc: lowest-set-bit encoder; rest_o is the mask with that bit cleared.
module spike_prio_enc #(
   parameter int W  = 256,
   parameter int IW = 8
) (
   input  logic [W-1:0]  mask_i,
   output logic [IW-1:0] idx_o,
   output logic [W-1:0]  rest_o,
   output logic          any_o,
   output logic          one_hot_last_o
);
   always_comb begin
      idx_o = '0;
      for (int i = W - 1; i >= 0; i--)
         if (mask_i[i]) idx_o = IW'(i);
   end
   assign rest_o         = mask_i & (mask_i - W'(1));
   assign any_o          = |mask_i;
   assign one_hot_last_o = any_o && (rest_o == '0);
endmodule

// File: rtl/ip_spike_sequencer.sv
// ip_spike_sequencer: walks spike-RAM rows and streams each row's set-bit indices in ascending order.
module ip_spike_sequencer
   import ip_spike_sequencer_pkg::*;
(
   input logic                  clk,
   input logic                  rst_n,
   ip_spike_sequencer_if.master bus
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] step_q, step_d, steps_q, steps_d, ram_addr_q, ram_addr_d, step_nx;
   logic [WIDTH-1:0]  mask_q, mask_d, mask_rest;
   logic [IDX_W-1:0]  idx;
   logic              any, last, xfer, row_end, step_done_q;

   spike_prio_enc #(.W(WIDTH), .IW(IDX_W)) u_enc (
      .mask_i        (mask_q),
      .idx_o         (idx),
      .rest_o        (mask_rest),
      .any_o         (any),
      .one_hot_last_o(last)
   );

   assign step_nx = step_q + ADDR_W'(1);
   assign xfer    = (state_q == S_SCAN) && any && bus.spk_ready;
   // An empty row ends on its first SCAN cycle without emitting anything.
   assign row_end = (state_q == S_SCAN) && (!any || (xfer && last));

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      steps_d    = steps_q;
      mask_d     = mask_q;
      ram_addr_d = ram_addr_q;
      case (state_q)
         S_IDLE: if (bus.start) begin
            steps_d    = clamp_steps(bus.num_steps);
            step_d     = '0;
            state_d    = (bus.num_steps == '0) ? S_DONE : S_ADDR;
            ram_addr_d = (bus.num_steps == '0) ? ram_addr_q : '0;
         end
         S_ADDR: state_d = S_WAIT;
         S_WAIT: state_d = S_LOAD;
         S_LOAD: begin
            mask_d  = bus.ram_data;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            mask_d = xfer ? mask_rest : mask_q;
            if (row_end) begin
               step_d     = step_nx;
               state_d    = (step_nx == steps_q) ? S_DONE : S_ADDR;
               ram_addr_d = (step_nx == steps_q) ? ram_addr_q : step_nx;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         step_q      <= '0;
         steps_q     <= '0;
         mask_q      <= '0;
         ram_addr_q  <= '0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         steps_q     <= steps_d;
         mask_q      <= mask_d;
         ram_addr_q  <= ram_addr_d;
         step_done_q <= row_end;
      end
   end

   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_we    = 1'b0;
   assign bus.spk_valid = (state_q == S_SCAN) && any;
   assign bus.spk_idx   = idx;
   assign bus.spk_step  = step_q;
   assign bus.spk_last  = last;
   assign bus.step_done = step_done_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
endmodule
